routing_unit: RTL and testbench
===============================

Name: routing_unit

Overview:
- Per-input-port route computation unit for the mesh router; one instance per input port, feeding the switch allocator.
- Generalises fixed XY dimension-order routing: runtime-selectable mode (XY, YX, west-first minimal adaptive).
- Registers the route on the head flit and locks it until the tail flit is granted.
- Flags malformed traffic and flags stalled packets via a watchdog counter.

Parameters:
- X_LOC, 0, router X coordinate
- Y_LOC, 0, router Y coordinate
- X_NODES, `X_NODES, mesh width (≥2)
- Y_NODES, `Y_NODES, mesh height (≥2)
- M, `M, output port count, fixed order [local, north, east, south, west]; must be 5
- STALL_CYCLES, 64, watchdog threshold in cycles (≥2)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_val  in  1  flit valid at this input
- i_head  in  1  flit is a head flit
- i_tail  in  1  flit is a tail flit; head and tail may both be set (single-flit packet)
- i_x_dest  in  $clog2(X_NODES)  destination X, sampled on the head flit only
- i_y_dest  in  $clog2(Y_NODES)  destination Y, sampled on the head flit only
- i_mode  in  2  0=XY, 1=YX, 2=west-first adaptive, 3=reserved (treated as XY)
- i_out_free  in  M  downstream output has credit/free VC; used only in mode 2
- i_grant  in  1  switch allocator granted this input's current flit
- o_output_req  out  M  one-hot output request, registered; all zeros when idle
- o_locked  out  1  a route is held, state ROUTED
- o_err  out  1  sticky protocol/destination error
- o_stall  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- Reset (async assert, sync deassert by flop design):
  - state=IDLE; o_output_req=0, o_locked=0, o_err=0, o_stall=0; watchdog=0.
- Route function (combinational, evaluated on i_val&i_head):
  - dx = dest_x vs X_LOC; dy = dest_y vs Y_LOC. North = y increasing; east = x increasing.
  - XY: resolve X first (east/west), then Y (north/south), else local.
  - YX: resolve Y first, then X, else local.
  - West-first:
    - If dest_x<X_LOC: west, deterministic.
    - Else productive set = {east if dest_x>X_LOC, north/south per dy}.
    - Single member: that port.
    - Two members: the first one with i_out_free set, preferring east. If neither is free, east.
  - dest==local coordinates → local, in every mode.
  - Destination out of range (i_x_dest≥X_NODES or i_y_dest≥Y_NODES, for non-power-of-2 meshes) → o_err set, no request, state stays IDLE.
- FSM IDLE:
  - On i_val&i_head with a valid destination: o_output_req ← route; state ← ROUTED. Latency is one cycle, head sample to request visible.
  - Non-head flit while IDLE (i_val&!i_head): o_err set, flit ignored.
- FSM ROUTED:
  - o_output_req and o_locked are held constant.
  - Mode, destination and i_out_free changes are ignored.
  - On i_val&i_grant&i_tail: next cycle o_output_req=0, o_locked=0, state ← IDLE. Back-to-back head is accepted from that next cycle.
  - Grant without tail: stay ROUTED, watchdog cleared.
  - i_val&i_head while ROUTED: o_err set, route unchanged.
- Single-flit packet (head&tail): routed in cycle N; released on the cycle after its grant.
- Watchdog (counter width $clog2(STALL_CYCLES+1)):
  - Increments each ROUTED cycle without i_grant; cleared on grant or in IDLE.
  - Reaching STALL_CYCLES: o_stall pulses high one cycle and the counter restarts from 0. The route stays locked; o_stall is diagnostic only.
- o_err clears only on reset.
- Reset mid-packet: immediate return to IDLE with all outputs 0; the remainder of the packet then raises o_err.

Decomposition:
- Shared package noc_pkg:
  - port index constants PORT_LOCAL..PORT_WEST;
  - route_mode_t enum (MODE_XY, MODE_YX, MODE_WF, MODE_RSVD);
  - rstate_t enum (IDLE, ROUTED);
  - one-hot constants REQ_LOCAL=5'b10000 … REQ_WEST=5'b00001.
- Sub-module route_compute: purely combinational mode/destination → one-hot. Reusable by a future lookahead router.
- FSM, watchdog and error logic stay in routing_unit.

Test Plan:
- XY at X_LOC=1,Y_LOC=1, 4x4, head to (3,0): request 5'b00100 (east) one cycle later; YX with the same destination → 5'b00010 (south).
- West-first at (1,1), head to (2,3):
  - i_out_free east=0, north=1 → 5'b01000.
  - Both free → 5'b00100.
  - Head to (0,3) → 5'b00001 regardless of i_out_free.
- 3-flit packet, grant on body and tail:
  - request held for all cycles, even with i_mode changed mid-packet;
  - zero the cycle after the tail grant;
  - next head accepted that cycle.
- Head to (1,1) at (1,1): 5'b10000. Single-flit packet: o_locked drops one cycle after its grant.
- Error cases:
  - body flit in IDLE → o_err=1 and it stays set;
  - second head while ROUTED → o_err=1 and the route is unchanged;
  - 3x3 mesh, dest x=3 → o_err=1, no request.
- STALL_CYCLES=4, ROUTED with no grant for 9 cycles: o_stall pulses at cycles 4 and 8. Asserting reset_n=0 mid-stall clears all outputs asynchronously.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: output port order, one-hot request encodings,
// routing modes and the per-input routing state.
package noc_pkg;

   localparam int NUM_PORTS  = 5;

   localparam int PORT_LOCAL = 0;
   localparam int PORT_NORTH = 1;
   localparam int PORT_EAST  = 2;
   localparam int PORT_SOUTH = 3;
   localparam int PORT_WEST  = 4;

   // Port 0 (local) maps to the MSB so the request vector reads in port order.
   localparam logic [NUM_PORTS-1:0] REQ_LOCAL = 5'b10000 >> PORT_LOCAL;
   localparam logic [NUM_PORTS-1:0] REQ_NORTH = 5'b10000 >> PORT_NORTH;
   localparam logic [NUM_PORTS-1:0] REQ_EAST  = 5'b10000 >> PORT_EAST;
   localparam logic [NUM_PORTS-1:0] REQ_SOUTH = 5'b10000 >> PORT_SOUTH;
   localparam logic [NUM_PORTS-1:0] REQ_WEST  = 5'b10000 >> PORT_WEST;

   typedef enum logic [1:0] {
      MODE_XY   = 2'd0,
      MODE_YX   = 2'd1,
      MODE_WF   = 2'd2,
      MODE_RSVD = 2'd3
   } route_mode_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ROUTED = 1'b1
   } rstate_t;

endpackage

// File: rtl/route_compute.sv
// Combinational route function: destination + mode -> one-hot output request.
// Latency: zero (pure logic). Backpressure: none, out_free only steers west-first choice.
// Reserved mode behaves as XY; destination equal to this node always routes local.
module route_compute
   import noc_pkg::*;
#(
   parameter int X_LOC = 0,
   parameter int Y_LOC = 0,
   parameter int XW    = 2,
   parameter int YW    = 2
) (
   input  logic [XW-1:0]        x_dest,
   input  logic [YW-1:0]        y_dest,
   input  route_mode_t          mode,
   input  logic [NUM_PORTS-1:0] out_free,
   output logic [NUM_PORTS-1:0] req
);

   logic                 go_east;
   logic                 go_west;
   logic                 go_north;
   logic                 go_south;
   logic [NUM_PORTS-1:0] req_xy;
   logic [NUM_PORTS-1:0] req_yx;
   logic [NUM_PORTS-1:0] req_vert;

   always_comb begin
      go_east  = int'(x_dest) > X_LOC;
      go_west  = int'(x_dest) < X_LOC;
      go_north = int'(y_dest) > Y_LOC;
      go_south = int'(y_dest) < Y_LOC;

      req_vert = go_north ? REQ_NORTH : (go_south ? REQ_SOUTH : REQ_LOCAL);

      req_xy = REQ_LOCAL;
      if (go_east)       req_xy = REQ_EAST;
      else if (go_west)  req_xy = REQ_WEST;
      else if (go_north) req_xy = REQ_NORTH;
      else if (go_south) req_xy = REQ_SOUTH;

      req_yx = REQ_LOCAL;
      if (go_north)      req_yx = REQ_NORTH;
      else if (go_south) req_yx = REQ_SOUTH;
      else if (go_east)  req_yx = REQ_EAST;
      else if (go_west)  req_yx = REQ_WEST;

      req = req_xy;
      case (mode)
         MODE_YX: req = req_yx;
         MODE_WF: begin
            // Westward hops go first and deterministically; otherwise pick among
            // productive ports, east preferred, east again if nothing is free.
            if (go_west) begin
               req = REQ_WEST;
            end else if (go_east && (go_north || go_south)) begin
               if ((out_free & REQ_EAST) != '0)      req = REQ_EAST;
               else if ((out_free & req_vert) != '0) req = req_vert;
               else                                  req = REQ_EAST;
            end else begin
               req = req_xy;
            end
         end
         default: req = req_xy;
      endcase
   end

endmodule

// File: rtl/routing_unit.sv
// Per-input route unit: computes the route on a head flit and holds it until the tail is granted.
// Latency: one cycle from head sample to registered request.
// Backpressure: route stays locked while ungranted; watchdog pulses o_stall every STALL_CYCLES idle-grant cycles.
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif
`ifndef M
`define M 5
`endif

module routing_unit
   import noc_pkg::*;
#(
   parameter int X_LOC        = 0,
   parameter int Y_LOC        = 0,
   parameter int X_NODES      = `X_NODES,
   parameter int Y_NODES      = `Y_NODES,
   parameter int M            = `M,
   parameter int STALL_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_val,
   input  logic                       i_head,
   input  logic                       i_tail,
   input  logic [$clog2(X_NODES)-1:0] i_x_dest,
   input  logic [$clog2(Y_NODES)-1:0] i_y_dest,
   input  logic [1:0]                 i_mode,
   input  logic [M-1:0]               i_out_free,
   input  logic                       i_grant,
   output logic [M-1:0]               o_output_req,
   output logic                       o_locked,
   output logic                       o_err,
   output logic                       o_stall
);

   localparam int XW  = $clog2(X_NODES);
   localparam int YW  = $clog2(Y_NODES);
   localparam int WDW = $clog2(STALL_CYCLES + 1);

   rstate_t        state_q, state_d;
   route_mode_t    mode;
   logic [M-1:0]   route;
   logic [M-1:0]   req_q, req_d;
   logic           err_q, err_d;
   logic           stall_q, stall_d;
   logic [WDW-1:0] wd_q, wd_d, wd_inc;
   logic           dest_ok;

   assign mode    = route_mode_t'(i_mode);
   // Only non-power-of-2 meshes can present an unreachable coordinate.
   assign dest_ok = (int'(i_x_dest) < X_NODES) && (int'(i_y_dest) < Y_NODES);
   assign wd_inc  = wd_q + 1'b1;

   route_compute #(
      .X_LOC (X_LOC),
      .Y_LOC (Y_LOC),
      .XW    (XW),
      .YW    (YW)
   ) u_route_compute (
      .x_dest   (i_x_dest),
      .y_dest   (i_y_dest),
      .mode     (mode),
      .out_free (i_out_free),
      .req      (route)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      err_d   = err_q;
      stall_d = 1'b0;
      wd_d    = '0;
      case (state_q)
         IDLE: begin
            if (i_val) begin
               if (!i_head || !dest_ok) begin
                  err_d = 1'b1;
               end else begin
                  req_d   = route;
                  state_d = ROUTED;
               end
            end
         end
         ROUTED: begin
            if (i_val && i_head) err_d = 1'b1;
            if (i_val && i_grant && i_tail) begin
               req_d   = '0;
               state_d = IDLE;
            end else if (!i_grant) begin
               // Counter wraps at the threshold so the pulse repeats while stuck.
               if (wd_inc == WDW'(STALL_CYCLES)) stall_d = 1'b1;
               else                              wd_d    = wd_inc;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         err_q   <= 1'b0;
         stall_q <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         err_q   <= err_d;
         stall_q <= stall_d;
         wd_q    <= wd_d;
      end
   end

   assign o_output_req = req_q;
   assign o_locked     = (state_q == ROUTED);
   assign o_err        = err_q;
   assign o_stall      = stall_q;

endmodule

// File: tb/tb_routing_unit.sv
// Directed bench for routing_unit: a 4x4 instance and a 3x3 instance at node (1,1)
// share all inputs; the 3x3 one is only inspected for out-of-range destinations.
module tb_routing_unit;

   logic       clk;
   logic       reset_n;
   logic       i_val, i_head, i_tail, i_grant;
   logic [1:0] i_x_dest, i_y_dest, i_mode;
   logic [4:0] i_out_free;
   logic [4:0] o_output_req, d3_output_req;
   logic       o_locked, o_err, o_stall;
   logic       d3_locked, d3_err, d3_stall;

   int checks = 0;
   int errors = 0;

   routing_unit #(
      .X_LOC(1), .Y_LOC(1), .X_NODES(4), .Y_NODES(4), .M(5), .STALL_CYCLES(4)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .i_val(i_val), .i_head(i_head), .i_tail(i_tail),
      .i_x_dest(i_x_dest), .i_y_dest(i_y_dest), .i_mode(i_mode), .i_out_free(i_out_free),
      .i_grant(i_grant), .o_output_req(o_output_req), .o_locked(o_locked),
      .o_err(o_err), .o_stall(o_stall)
   );

   routing_unit #(
      .X_LOC(1), .Y_LOC(1), .X_NODES(3), .Y_NODES(3), .M(5), .STALL_CYCLES(4)
   ) u_dut3 (
      .clk(clk), .reset_n(reset_n), .i_val(i_val), .i_head(i_head), .i_tail(i_tail),
      .i_x_dest(i_x_dest), .i_y_dest(i_y_dest), .i_mode(i_mode), .i_out_free(i_out_free),
      .i_grant(i_grant), .o_output_req(d3_output_req), .o_locked(d3_locked),
      .o_err(d3_err), .o_stall(d3_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      i_val   = 1'b0;
      i_head  = 1'b0;
      i_tail  = 1'b0;
      i_grant = 1'b0;
   endtask

   task automatic apply_reset();
      drive_idle();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      step();
   endtask

   task automatic send_head(input logic [1:0] x, input logic [1:0] y, input logic [1:0] mode,
                            input logic [4:0] free, input logic tail);
      i_val      = 1'b1;
      i_head     = 1'b1;
      i_tail     = tail;
      i_grant    = 1'b0;
      i_x_dest   = x;
      i_y_dest   = y;
      i_mode     = mode;
      i_out_free = free;
      step();
      drive_idle();
   endtask

   task automatic grant_tail();
      i_val   = 1'b1;
      i_head  = 1'b0;
      i_tail  = 1'b1;
      i_grant = 1'b1;
      step();
      drive_idle();
   endtask

   task automatic test_reset();
      drive_idle();
      i_x_dest = 2'd0; i_y_dest = 2'd0; i_mode = 2'd0; i_out_free = 5'b00000;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      checks++; if (o_output_req !== 5'b00000) begin errors++; $display("FAIL reset_req got=%b exp=%b", o_output_req, 5'b00000); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", o_locked); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", o_err); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
      @(posedge clk);
      #1 reset_n = 1'b1;
      step();
   endtask

   task automatic test_xy_yx();
      apply_reset();
      send_head(2'd3, 2'd0, 2'd0, 5'b00000, 1'b0);
      checks++; if (o_output_req !== 5'b00100) begin errors++; $display("FAIL xy_east got=%b exp=%b", o_output_req, 5'b00100); end
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL xy_locked got=%b exp=1", o_locked); end
      grant_tail();
      checks++; if (o_output_req !== 5'b00000) begin errors++; $display("FAIL xy_release got=%b exp=%b", o_output_req, 5'b00000); end
      send_head(2'd3, 2'd0, 2'd1, 5'b00000, 1'b0);
      checks++; if (o_output_req !== 5'b00010) begin errors++; $display("FAIL yx_south got=%b exp=%b", o_output_req, 5'b00010); end
      grant_tail();
      send_head(2'd3, 2'd0, 2'd3, 5'b00000, 1'b0);
      checks++; if (o_output_req !== 5'b00100) begin errors++; $display("FAIL rsvd_as_xy got=%b exp=%b", o_output_req, 5'b00100); end
      grant_tail();
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL xy_no_err got=%b exp=0", o_err); end
   endtask

   task automatic test_west_first();
      apply_reset();
      send_head(2'd2, 2'd3, 2'd2, 5'b01000, 1'b0);
      checks++; if (o_output_req !== 5'b01000) begin errors++; $display("FAIL wf_north_free got=%b exp=%b", o_output_req, 5'b01000); end
      grant_tail();
      send_head(2'd2, 2'd3, 2'd2, 5'b01100, 1'b0);
      checks++; if (o_output_req !== 5'b00100) begin errors++; $display("FAIL wf_both_free got=%b exp=%b", o_output_req, 5'b00100); end
      grant_tail();
      send_head(2'd2, 2'd3, 2'd2, 5'b00000, 1'b0);
      checks++; if (o_output_req !== 5'b00100) begin errors++; $display("FAIL wf_none_free got=%b exp=%b", o_output_req, 5'b00100); end
      grant_tail();
      send_head(2'd0, 2'd3, 2'd2, 5'b11111, 1'b0);
      checks++; if (o_output_req !== 5'b00001) begin errors++; $display("FAIL wf_west got=%b exp=%b", o_output_req, 5'b00001); end
      grant_tail();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      send_head(2'd1, 2'd3, 2'd0, 5'b00000, 1'b0);
      checks++; if (o_output_req !== 5'b01000) begin errors++; $display("FAIL pkt_head got=%b exp=%b", o_output_req, 5'b01000); end
      // body flit granted while mode, destination and free mask all change
      i_val = 1'b1; i_grant = 1'b1; i_mode = 2'd1; i_x_dest = 2'd3; i_y_dest = 2'd0; i_out_free = 5'b00100;
      step();
      checks++; if (o_output_req !== 5'b01000) begin errors++; $display("FAIL pkt_body_hold got=%b exp=%b", o_output_req, 5'b01000); end
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL pkt_body_locked got=%b exp=1", o_locked); end
      i_mode = 2'd2; i_tail = 1'b1;
      step();
      drive_idle();
      checks++; if (o_output_req !== 5'b00000) begin errors++; $display("FAIL pkt_tail_clear got=%b exp=%b", o_output_req, 5'b00000); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL pkt_tail_unlock got=%b exp=0", o_locked); end
      send_head(2'd3, 2'd1, 2'd0, 5'b00000, 1'b0);
      checks++; if (o_output_req !== 5'b00100) begin errors++; $display("FAIL pkt_next_head got=%b exp=%b", o_output_req, 5'b00100); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL pkt_no_err got=%b exp=0", o_err); end
      grant_tail();
   endtask

   task automatic test_local_single();
      apply_reset();
      send_head(2'd1, 2'd1, 2'd2, 5'b00000, 1'b0);
      checks++; if (o_output_req !== 5'b10000) begin errors++; $display("FAIL local_wf got=%b exp=%b", o_output_req, 5'b10000); end
      grant_tail();
      send_head(2'd1, 2'd1, 2'd0, 5'b00000, 1'b1);
      checks++; if (o_output_req !== 5'b10000) begin errors++; $display("FAIL single_req got=%b exp=%b", o_output_req, 5'b10000); end
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL single_locked got=%b exp=1", o_locked); end
      grant_tail();
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL single_unlock got=%b exp=0", o_locked); end
      checks++; if (o_output_req !== 5'b00000) begin errors++; $display("FAIL single_clear got=%b exp=%b", o_output_req, 5'b00000); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL single_no_err got=%b exp=0", o_err); end
   endtask

   task automatic test_errors();
      apply_reset();
      i_val = 1'b1;
      step();
      drive_idle();
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL body_idle_err got=%b exp=1", o_err); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL body_idle_locked got=%b exp=0", o_locked); end
      step();
      step();
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", o_err); end
      apply_reset();
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_reset_clear got=%b exp=0", o_err); end
      send_head(2'd3, 2'd0, 2'd0, 5'b00000, 1'b0);
      send_head(2'd0, 2'd0, 2'd0, 5'b00000, 1'b0);
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL dup_head_err got=%b exp=1", o_err); end
      checks++; if (o_output_req !== 5'b00100) begin errors++; $display("FAIL dup_head_route got=%b exp=%b", o_output_req, 5'b00100); end
      apply_reset();
      send_head(2'd3, 2'd0, 2'd0, 5'b00000, 1'b0);
      checks++; if (d3_err !== 1'b1) begin errors++; $display("FAIL range_err got=%b exp=1", d3_err); end
      checks++; if (d3_output_req !== 5'b00000) begin errors++; $display("FAIL range_req got=%b exp=%b", d3_output_req, 5'b00000); end
      checks++; if (d3_locked !== 1'b0) begin errors++; $display("FAIL range_locked got=%b exp=0", d3_locked); end
   endtask

   task automatic test_stall();
      logic exp_stall;
      apply_reset();
      send_head(2'd3, 2'd3, 2'd0, 5'b00000, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         step();
         exp_stall = (k == 4) || (k == 8);
         checks++; if (o_stall !== exp_stall) begin errors++; $display("FAIL stall_cycle%0d got=%b exp=%b", k, o_stall, exp_stall); end
      end
      checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL stall_still_locked got=%b exp=1", o_locked); end
      step();
      reset_n = 1'b0;
      #2;
      checks++; if (o_output_req !== 5'b00000) begin errors++; $display("FAIL midreset_req got=%b exp=%b", o_output_req, 5'b00000); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL midreset_locked got=%b exp=0", o_locked); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL midreset_stall got=%b exp=0", o_stall); end
      reset_n = 1'b1;
      step();
      grant_tail();
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL orphan_tail_err got=%b exp=1", o_err); end
      checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL orphan_tail_locked got=%b exp=0", o_locked); end
   endtask

   initial begin
      test_reset();
      test_xy_yx();
      test_west_first();
      test_back_to_back();
      test_local_single();
      test_errors();
      test_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
